// File: rtl/tff_chain_sched.sv
// Round-robin scheduler sharing one toggle-flip-flop chain among NREQ requesters:
// grant, clear the chain, hold toggle-enable for the latched burst length, then pulse done.
module tff_chain_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*CW-1:0] i_len,
  output logic [NREQ-1:0]    o_gnt,
  output logic               o_busy,
  output logic               o_t_clr,
  output logic               o_t_en,
  output logic [NREQ-1:0]    o_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win;
  logic [CW-1:0]   r_rem;

  logic [CW-1:0]   w_len_arr [NREQ];
  logic            w_found;
  logic [PW-1:0]   w_idx;
  logic [NREQ-1:0] w_idx_oh;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_len_arr[i] = i_len[i*CW +: CW];
    end
  end

  // Search starts at the priority pointer and wraps; the first asserted request wins.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && i_req[j]) begin
        w_found = 1'b1;
        w_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    w_idx_oh        = '0;
    w_idx_oh[w_idx] = 1'b1;
  end

  // The grant vector is held from CLEAR through DONE, so done simply copies it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_rem   <= '0;
      o_gnt   <= '0;
      o_busy  <= 1'b0;
      o_t_clr <= 1'b0;
      o_t_en  <= 1'b0;
      o_done  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_CLEAR;
            r_win   <= w_idx;
            r_rem   <= w_len_arr[w_idx];
            o_gnt   <= w_idx_oh;
            o_busy  <= 1'b1;
            o_t_clr <= 1'b1;
          end
        end
        S_CLEAR: begin
          o_t_clr <= 1'b0;
          if (r_rem != '0) begin
            r_state <= S_RUN;
            o_t_en  <= 1'b1;
          end else begin
            r_state <= S_DONE;
            o_done  <= o_gnt;
          end
        end
        S_RUN: begin
          r_rem <= r_rem - 1'b1;
          if (r_rem == CW'(1)) begin
            r_state <= S_DONE;
            o_t_en  <= 1'b0;
            o_done  <= o_gnt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          o_gnt   <= '0;
          o_done  <= '0;
          o_busy  <= 1'b0;
          r_ptr   <= (r_win == PW'(NREQ-1)) ? '0 : r_win + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_chain_sched.sv
// Directed self-checking bench for tff_chain_sched: single burst, round-robin,
// zero and maximum length, reset mid-burst, and mid-burst input changes.
module tb_tff_chain_sched;

  localparam int NREQ = 4;
  localparam int CW   = 8;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               tClr;
  logic               tEn;
  logic [NREQ-1:0]    done;

  int testsRun;
  int testsFailed;

  tff_chain_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  (req),
    .i_len  (len),
    .o_gnt  (gnt),
    .o_busy (busy),
    .o_t_clr(tClr),
    .o_t_en (tEn),
    .o_done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NREQ*CW-1:0] packLen(input int l0, input int l1, input int l2, input int l3);
    return {CW'(l3), CW'(l2), CW'(l1), CW'(l0)};
  endfunction

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] l);
    req = r;
    len = l;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] g, input logic b,
                          input logic c, input logic e, input logic [3:0] d);
    checkOutput({tag, "_gnt"},  32'(gnt),  32'(g));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(b));
    checkOutput({tag, "_clr"},  32'(tClr), 32'(c));
    checkOutput({tag, "_en"},   32'(tEn),  32'(e));
    checkOutput({tag, "_done"}, 32'(done), 32'(d));
  endtask

  initial begin
    logic [3:0] rrGnt [4];
    int cnt;
    testsRun    = 0;
    testsFailed = 0;
    rrGnt[0] = 4'b0001;
    rrGnt[1] = 4'b0010;
    rrGnt[2] = 4'b1000;
    rrGnt[3] = 4'b0001;

    // Reset state
    rst = 1'b1;
    applyStimulus(4'b0000, '0);
    tick();
    tick();
    checkAll("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    rst = 1'b0;
    tick();
    checkAll("idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Single request, len0 = 3
    applyStimulus(4'b0001, packLen(3, 0, 0, 0));
    tick();
    checkAll("single_clear", 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b0000, packLen(3, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("single_run", 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000);
    end
    tick();
    checkAll("single_done", 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001);
    tick();
    checkAll("single_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Round-robin from ptr 0 with req 1011 held, all len 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b1011, packLen(1, 1, 1, 1));
    for (int b = 0; b < 4; b++) begin
      tick();
      checkAll("rr_clear", rrGnt[b], 1'b1, 1'b1, 1'b0, 4'b0000);
      tick();
      checkAll("rr_run", rrGnt[b], 1'b1, 1'b0, 1'b1, 4'b0000);
      tick();
      checkAll("rr_done", rrGnt[b], 1'b1, 1'b0, 1'b0, rrGnt[b]);
      if (b == 3) applyStimulus(4'b0000, packLen(1, 1, 1, 1));
      tick();
      checkAll("rr_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    end

    // Zero length on requester 2 (ptr is 1)
    applyStimulus(4'b0100, packLen(0, 0, 0, 0));
    tick();
    checkAll("zero_clear", 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b0000, packLen(0, 0, 0, 0));
    tick();
    checkAll("zero_done", 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100);
    tick();
    checkAll("zero_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Maximum length on requester 1 (ptr is 3, search 3,0,1)
    applyStimulus(4'b0010, packLen(0, 255, 0, 0));
    tick();
    checkAll("max_clear", 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b0000, packLen(0, 255, 0, 0));
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (done != 4'b0000) break;
      if (tEn) cnt++;
    end
    checkOutput("max_en_count", 32'(cnt), 32'd255);
    checkAll("max_done", 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010);
    tick();
    checkAll("max_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Reset mid-RUN (ptr is 2, search 2,3,0)
    applyStimulus(4'b0001, packLen(10, 0, 0, 0));
    tick();
    checkAll("rstrun_clear", 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkAll("rstrun_run", 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000);
    end
    rst = 1'b1;
    tick();
    checkAll("rstrun_abort", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    rst = 1'b0;
    applyStimulus(4'b0011, packLen(1, 1, 1, 1));
    tick();
    checkAll("rstrun_regrant", 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b0000, packLen(1, 1, 1, 1));
    tick();
    checkAll("rstrun_run2", 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000);
    tick();
    checkAll("rstrun_done2", 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001);
    tick();
    checkAll("rstrun_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // len and req change mid-burst (len0 5 -> 2, req dropped)
    applyStimulus(4'b0001, packLen(5, 0, 0, 0));
    tick();
    checkAll("chg_clear", 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    checkAll("chg_run1", 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000);
    applyStimulus(4'b0000, packLen(2, 0, 0, 0));
    cnt = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done != 4'b0000) break;
      if (tEn) cnt++;
    end
    checkOutput("chg_en_count", 32'(cnt), 32'd5);
    checkAll("chg_done", 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001);
    tick();
    checkAll("chg_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checkAll("chg_stay_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
